// File: rtl/parity_mem_arb_pkg.sv
// Shared defaults and FSM state encoding for the parity-checked memory arbiter.
package mem_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_CHECK = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic ptr;

   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
   end

   // After a grant, priority passes to the requester that did not win.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= 1'b0;
      else if (advance && (gnt != 2'b00))
         ptr <= gnt[0];
   end

endmodule

// File: rtl/parity_mem_arb.sv
// Two-requester memory front end: round-robin grant, single access, parity check on reads.
module parity_mem_arb
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned NREQ   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   input  logic [1:0]            req_write,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic [1:0]            req_ready,
   output logic [1:0]            rsp_valid,
   input  logic [1:0]            rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_perr,
   output logic                  mem_write,
   output logic                  mem_read,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W:0]       mem_rdata,
   output logic [7:0]            perr_count
);

   state_e              state;
   logic                gnt_idx;
   logic                lat_write;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [DATA_W-1:0]   rdata_q;
   logic                perr_q;
   logic [7:0]          perr_cnt;
   logic                in_idle;
   logic [1:0]          arb_req;
   logic [1:0]          gnt;
   logic                perr_calc;

   // Gating with rst_n keeps req_ready low while reset is held.
   assign in_idle = rst_n && (state == ST_IDLE);
   assign arb_req = req_valid & {2{in_idle}};

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (arb_req),
      .advance (in_idle),
      .gnt     (gnt)
   );

   assign perr_calc = mem_rdata[DATA_W] ^ (^mem_rdata[DATA_W-1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         gnt_idx   <= 1'b0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata_q   <= '0;
         perr_q    <= 1'b0;
         perr_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt != 2'b00) begin
                  gnt_idx   <= gnt[1];
                  lat_write <= req_write[gnt[1]];
                  lat_addr  <= gnt[1] ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
                  lat_wdata <= gnt[1] ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (lat_write) begin
                  rdata_q <= '0;
                  perr_q  <= 1'b0;
                  state   <= ST_RESP;
               end else begin
                  state   <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               rdata_q <= mem_rdata[DATA_W-1:0];
               perr_q  <= perr_calc;
               if (perr_calc && (perr_cnt != 8'hFF))
                  perr_cnt <= perr_cnt + 8'd1;
               state   <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready[gnt_idx]) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = gnt;
   assign rsp_valid  = (state == ST_RESP) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_rdata  = rdata_q;
   assign rsp_perr   = perr_q;
   assign mem_write  = (state == ST_ISSUE) &&  lat_write;
   assign mem_read   = (state == ST_ISSUE) && !lat_write;
   assign mem_addr   = lat_addr;
   assign mem_wdata  = lat_wdata;
   assign perr_count = perr_cnt;

endmodule

// File: tb/tb_parity_mem_arb.sv
// Scoreboard bench for parity_mem_arb with a behavioural parity memory.
module tb_parity_mem_arb;

   localparam int AW = 16;
   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_write = '0;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*DW-1:0] req_wdata = '0;
   logic [1:0]      req_ready;
   logic [1:0]      rsp_valid;
   logic [1:0]      rsp_ready = 2'b11;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_perr;
   logic            mem_write;
   logic            mem_read;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW:0]     mem_rdata = '0;
   logic [7:0]      perr_count;

   parity_mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_perr   (rsp_perr),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .perr_count (perr_count)
   );

   always #5 clk = ~clk;

   // Memory stores {even parity, data}; force_perr corrupts read data.
   logic [DW:0] mem [logic [AW-1:0]];
   bit          force_perr = 1'b0;
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] = {^mem_wdata, mem_wdata};
      if (mem_read)
         mem_rdata <= force_perr ? 9'h103 : (mem.exists(mem_addr) ? mem[mem_addr] : 9'h000);
   end

   typedef struct {
      int         req;
      logic [7:0] rdata;
      logic       perr;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_errors = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void timeout(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && ((rsp_valid & rsp_ready) != 2'b00)) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding", rsp_valid);
         end else begin
            e = sb.pop_front();
            check("rsp_who", {30'd0, rsp_valid}, 32'(2'b01 << e.req));
            check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
            check("rsp_perr", {31'd0, rsp_perr}, {31'd0, e.perr});
         end
      end
   end

   task automatic set_req(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[r]          = 1'b1;
      req_write[r]          = wr;
      req_addr[r*AW +: AW]  = a;
      req_wdata[r*DW +: DW] = d;
   endtask

   task automatic wait_accept(input int r, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready[r]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("accept");
   endtask

   task automatic drain();
      for (int i = 0; i < 50; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check("sb_drained", sb.size(), 0);
   endtask

   // Full transaction with latency checks; the monitor checks the response contents.
   task automatic txn(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp_rd, input bit exp_perr);
      bit ok;
      @(posedge clk); #1;
      set_req(r, wr, a, d);
      sb.push_back('{r, exp_rd, exp_perr});
      wait_accept(r, ok);
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
      if (!ok) return;
      @(negedge clk);
      check("mem_write_T1", {31'd0, mem_write}, {31'd0, wr});
      check("mem_read_T1", {31'd0, mem_read}, {31'd0, !wr});
      check("mem_addr_T1", {16'd0, mem_addr}, {16'd0, a});
      if (wr) check("mem_wdata_T1", {24'd0, mem_wdata}, {24'd0, d});
      @(negedge clk);
      if (!wr) begin
         check("rsp_valid_T2_read", {30'd0, rsp_valid}, 0);
         @(negedge clk);
      end
      check("rsp_valid_latency", {30'd0, rsp_valid}, 32'(2'b01 << r));
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit   ok;
      bit   got [4];
      bit   exp_order [4];
      int   g;
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};

      // Reset state
      #12;
      check("rst_req_ready", {30'd0, req_ready}, 0);
      check("rst_rsp_valid", {30'd0, rsp_valid}, 0);
      check("rst_mem_strobes", {30'd0, mem_write, mem_read}, 0);
      check("rst_perr_count", {24'd0, perr_count}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Both requesters held valid: grants alternate 0,1,0,1
      @(posedge clk); #1;
      set_req(0, 1'b1, 16'h0020, 8'h11);
      set_req(1, 1'b1, 16'h0030, 8'h22);
      for (int k = 0; k < 4; k++) sb.push_back('{k % 2, 8'h00, 1'b0});
      g = 0;
      for (int i = 0; i < 100 && g < 4; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            got[g] = req_ready[1];
            g++;
         end
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      if (g < 4) timeout("alternate_grants");
      for (int k = 0; k < 4; k++) check($sformatf("grant_order_%0d", k), {31'd0, got[k]}, {31'd0, exp_order[k]});
      drain();

      // Write 0xA5 then read it back
      txn(0, 1'b1, 16'h0010, 8'hA5, 8'h00, 1'b0);
      txn(0, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0);
      drain();

      // Response back-pressure for 5 cycles with requester 1 waiting
      @(posedge clk); #1;
      rsp_ready[0] = 1'b0;
      set_req(0, 1'b0, 16'h0010, 8'h00);
      sb.push_back('{0, 8'hA5, 1'b0});
      wait_accept(0, ok);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      set_req(1, 1'b1, 16'h0050, 8'h3C);
      sb.push_back('{1, 8'h00, 1'b0});
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid[0]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("hold_rsp_valid");
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         check("hold_rsp_valid", {30'd0, rsp_valid}, 1);
         check("hold_rsp_rdata", {24'd0, rsp_rdata}, 32'hA5);
         check("hold_req_ready", {30'd0, req_ready}, 0);
      end
      @(posedge clk); #1;
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      check("hold_last_valid", {30'd0, rsp_valid}, 1);
      @(negedge clk);
      check("hold_exit_valid", {30'd0, rsp_valid}, 0);
      check("hold_next_grant", {30'd0, req_ready}, 2);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      drain();

      // Parity errors: first detection, then saturation
      force_perr = 1'b1;
      txn(0, 1'b0, 16'h0040, 8'h00, 8'h03, 1'b1);
      check("perr_count_first", {24'd0, perr_count}, 1);
      for (int i = 0; i < 299; i++) txn(i % 2, 1'b0, 16'h0040, 8'h00, 8'h03, 1'b1);
      check("perr_count_sat", {24'd0, perr_count}, 255);
      force_perr = 1'b0;
      drain();

      // Reset asserted during CHECK; pointer left at requester 1 beforehand
      txn(0, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0);
      drain();
      @(posedge clk); #1;
      set_req(0, 1'b0, 16'h0010, 8'h00);
      wait_accept(0, ok);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", {req_ready, rsp_valid, mem_write, mem_read, rsp_perr}, 0);
      check("midrst_rdata", {24'd0, rsp_rdata}, 0);
      check("midrst_addr", {16'd0, mem_addr}, 0);
      check("midrst_perr_count", {24'd0, perr_count}, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("inrst_quiet", {rsp_valid, mem_write, mem_read}, 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst_quiet", {rsp_valid, mem_write, mem_read}, 0);

      // After reset both request: requester 0 first; 0xFFFF never written
      @(posedge clk); #1;
      set_req(0, 1'b0, 16'h0010, 8'h00);
      set_req(1, 1'b0, 16'hFFFF, 8'h00);
      sb.push_back('{0, 8'hA5, 1'b0});
      sb.push_back('{1, 8'h00, 1'b0});
      @(negedge clk);
      check("postrst_grant", {30'd0, req_ready}, 1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      wait_accept(1, ok);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/parity_mem_arb.md
PARITY_MEM_ARB -- requirements
Module: parity_mem_arb

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, default 16, memory address width.
- DATA_W, default 8, data width excluding parity.
- NREQ, fixed at 2, number of requesters.

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_write  in  2  per-requester: 1 = write, 0 = read.
- req_addr  in  2xADDR_W  per-requester address.
- req_wdata  in  2xDATA_W  per-requester write data.
- req_ready  out  2  per-requester accept strobe.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_rdata  out  DATA_W  read data, shared bus, qualified by rsp_valid.
- rsp_perr  out  1  parity error flag for the current response.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data; the memory appends even parity.
- mem_rdata  in  DATA_W+1  memory read data, {parity, data}; registered by memory, valid one cycle after mem_read.
- perr_count  out  8  saturating count of parity errors.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, CHECK and RESP.
REQ-004 In IDLE with at least one req_valid, the block SHALL assert req_ready for exactly one granted requester for one cycle, latch that requester's write, addr and wdata, and go to ISSUE.
REQ-005 Arbitration SHALL be round-robin.
- The priority pointer SHALL move to the non-granted requester after every grant.
- A lone requester SHALL be granted regardless of the pointer.
REQ-006 ISSUE SHALL last exactly one cycle.
- mem_write=1 for a write, or mem_read=1 for a read.
- mem_addr and mem_wdata SHALL be driven from the latched values.
- A write SHALL go next to RESP; a read SHALL go next to CHECK.
REQ-007 mem_write and mem_read SHALL never both be 1, and SHALL be 0 in every state other than ISSUE.
REQ-008 CHECK SHALL register the following, then go to RESP:
- rsp_rdata = mem_rdata[DATA_W-1:0].
- rsp_perr = mem_rdata[DATA_W] XOR (XOR-reduce of mem_rdata[DATA_W-1:0]).
REQ-009 On a write, RESP SHALL present rsp_rdata=0 and rsp_perr=0.
REQ-010 In RESP, rsp_valid SHALL be 1 only for the granted requester and SHALL hold, with rsp_rdata and rsp_perr stable, until that requester's rsp_ready=1.
- On that rsp_ready, the FSM SHALL go to IDLE.
- rsp_ready from the non-granted requester SHALL be ignored.
REQ-011 Latency SHALL be fixed:
- Read: accept cycle T, mem_read at T+1, rsp_valid from T+3.
- Write: mem_write at T+1, rsp_valid from T+2.
REQ-012 req_ready SHALL be 0 in ISSUE, CHECK and RESP; a request held valid SHALL wait there without loss.
REQ-013 perr_count SHALL increment by 1 in each CHECK cycle with a detected parity error, and SHALL saturate at 255.
REQ-014 A read of a never-written address returns 0 from the memory; the block SHALL report rsp_rdata=0 and rsp_perr=0.
REQ-015 A new grant SHALL NOT occur in the cycle RESP exits; the earliest next accept is the first IDLE cycle.

Reset
REQ-016 rst_n=0 SHALL asynchronously force the following, including mid-transaction:
- State = IDLE, with no memory strobe issued afterward.
- Priority pointer = requester 0.
- All outputs = 0, including perr_count.
REQ-017 A transaction interrupted by reset SHALL be dropped, with no response.

Structure
REQ-018 A shared package mem_pkg SHALL hold ADDR_W and DATA_W defaults and the FSM state enum.
REQ-019 Round-robin selection SHALL be a sub-module rr_arb2 with:
- inputs req[1:0] and advance;
- outputs gnt[1:0], one-hot or zero;
- its own pointer flop.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Req0 writes 0xA5 to 0x0010, then reads 0x0010 -> mem_write at T+1 with mem_wdata=0xA5; read returns rsp_rdata=0xA5, rsp_perr=0, rsp_valid at accept+3.
- Both requesters valid continuously after reset -> grants alternate 0,1,0,1 for 4 transactions.
- Memory model forces mem_rdata=9'h1_03 on a read -> rsp_perr=1 and perr_count becomes 1; 300 such reads -> perr_count=255.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable for 5 cycles, req_ready stays 0, and the FSM exits on the first rsp_ready=1.
- rst_n pulsed low during CHECK -> all outputs 0 immediately, no rsp_valid, next request accepted normally with pointer at requester 0.
- Read of never-written 0xFFFF -> rsp_rdata=0x00, rsp_perr=0.
